// File: rtl/parser_segs_fifo.sv
// Paired segment/VLAN FIFO for the header parser: header segments and the packet VLAN
// arrive on independent strobes and are popped together as one first-word-fall-through entry.
module parser_segs_fifo #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 4,
    parameter int C_DEPTH_LOG2       = 3
) (
    input  logic                                    axis_clk,
    input  logic                                    axis_rst,
    input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] s_segs_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]           s_tuser_1st,
    input  logic                                    s_segs_valid,
    input  logic [11:0]                             s_vlan,
    input  logic                                    s_vlan_valid,
    output logic                                    segs_fifo_ready,
    output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] m_segs_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]           m_tuser_1st,
    output logic [11:0]                             m_vlan,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [C_DEPTH_LOG2:0]                   seg_count,
    output logic                                    overflow_err
);

    localparam int DEPTH  = 1 << C_DEPTH_LOG2;
    localparam int VDEPTH = DEPTH + 1;
    localparam int SEGS_W = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
    localparam int CW     = C_DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] SEG_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] VLAN_FULL = CW'(VDEPTH);
    localparam logic [CW-1:0] READY_LIM = CW'(DEPTH - 1);
    localparam logic [CW-1:0] VLAN_LAST = CW'(VDEPTH - 1);

    logic [SEGS_W-1:0]             seg_mem   [DEPTH];
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_mem [DEPTH];
    logic [11:0]                   vlan_mem  [VDEPTH];

    logic [C_DEPTH_LOG2-1:0] seg_wr_q, seg_wr_d, seg_rd_q, seg_rd_d;
    logic [CW-1:0]           seg_cnt_q, seg_cnt_d;
    logic [CW-1:0]           vlan_wr_q, vlan_wr_d, vlan_rd_q, vlan_rd_d;
    logic [CW-1:0]           vlan_cnt_q, vlan_cnt_d;
    logic                    ovf_q, ovf_d;

    logic rd_en, seg_wr_en, vlan_wr_en;

    // A full FIFO still accepts a write in the same cycle as a pop, since the pop frees the slot first.
    always_comb begin
        m_valid    = !axis_rst && (seg_cnt_q != '0) && (vlan_cnt_q != '0);
        rd_en      = m_valid && m_ready;
        seg_wr_en  = s_segs_valid && ((seg_cnt_q != SEG_FULL) || rd_en);
        vlan_wr_en = s_vlan_valid && ((vlan_cnt_q != VLAN_FULL) || rd_en);

        seg_wr_d   = seg_wr_q;
        seg_rd_d   = seg_rd_q;
        seg_cnt_d  = seg_cnt_q;
        vlan_wr_d  = vlan_wr_q;
        vlan_rd_d  = vlan_rd_q;
        vlan_cnt_d = vlan_cnt_q;
        ovf_d      = ovf_q | (s_segs_valid && !seg_wr_en) | (s_vlan_valid && !vlan_wr_en);

        if (seg_wr_en) begin
            seg_wr_d = seg_wr_q + 1'b1;
        end
        if (rd_en) begin
            seg_rd_d  = seg_rd_q + 1'b1;
            vlan_rd_d = (vlan_rd_q == VLAN_LAST) ? '0 : vlan_rd_q + 1'b1;
        end
        if (vlan_wr_en) begin
            vlan_wr_d = (vlan_wr_q == VLAN_LAST) ? '0 : vlan_wr_q + 1'b1;
        end

        if (seg_wr_en && !rd_en) begin
            seg_cnt_d = seg_cnt_q + 1'b1;
        end else if (!seg_wr_en && rd_en) begin
            seg_cnt_d = seg_cnt_q - 1'b1;
        end
        if (vlan_wr_en && !rd_en) begin
            vlan_cnt_d = vlan_cnt_q + 1'b1;
        end else if (!vlan_wr_en && rd_en) begin
            vlan_cnt_d = vlan_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            seg_wr_q   <= '0;
            seg_rd_q   <= '0;
            seg_cnt_q  <= '0;
            vlan_wr_q  <= '0;
            vlan_rd_q  <= '0;
            vlan_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            seg_wr_q   <= seg_wr_d;
            seg_rd_q   <= seg_rd_d;
            seg_cnt_q  <= seg_cnt_d;
            vlan_wr_q  <= vlan_wr_d;
            vlan_rd_q  <= vlan_rd_d;
            vlan_cnt_q <= vlan_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage is left unreset; the pointers alone decide what is valid.
    always_ff @(posedge axis_clk) begin
        if (seg_wr_en) begin
            seg_mem[seg_wr_q]   <= s_segs_tdata;
            tuser_mem[seg_wr_q] <= s_tuser_1st;
        end
        if (vlan_wr_en) begin
            vlan_mem[vlan_wr_q] <= s_vlan;
        end
    end

    always_comb begin
        m_segs_tdata    = m_valid ? seg_mem[seg_rd_q] : '0;
        m_tuser_1st     = m_valid ? tuser_mem[seg_rd_q] : '0;
        m_vlan          = m_valid ? vlan_mem[vlan_rd_q] : '0;
        segs_fifo_ready = !axis_rst && (seg_cnt_q < READY_LIM);
        seg_count       = seg_cnt_q;
        overflow_err    = ovf_q;
    end

endmodule

// File: tb/tb_parser_segs_fifo.sv
// Directed bench for parser_segs_fifo: a per-cycle vector table for basic flow,
// then hand-written fill/overflow, reset-mid-operation and wrap sequences.
module tb_parser_segs_fifo;

    localparam int SW = 4 * 256;
    localparam int TW = 128;

    logic          clk;
    logic          rst;
    logic [SW-1:0] s_segs_tdata;
    logic [TW-1:0] s_tuser_1st;
    logic          s_segs_valid;
    logic [11:0]   s_vlan;
    logic          s_vlan_valid;
    logic          segs_fifo_ready;
    logic [SW-1:0] m_segs_tdata;
    logic [TW-1:0] m_tuser_1st;
    logic [11:0]   m_vlan;
    logic          m_valid;
    logic          m_ready;
    logic [3:0]    seg_count;
    logic          overflow_err;

    int total  = 0;
    int passed = 0;

    parser_segs_fifo dut (
        .axis_clk        (clk),
        .axis_rst        (rst),
        .s_segs_tdata    (s_segs_tdata),
        .s_tuser_1st     (s_tuser_1st),
        .s_segs_valid    (s_segs_valid),
        .s_vlan          (s_vlan),
        .s_vlan_valid    (s_vlan_valid),
        .segs_fifo_ready (segs_fifo_ready),
        .m_segs_tdata    (m_segs_tdata),
        .m_tuser_1st     (m_tuser_1st),
        .m_vlan          (m_vlan),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .seg_count       (seg_count),
        .overflow_err    (overflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        sv;
        int          sid;
        logic        vv;
        logic [11:0] vlan;
        logic        mr;
        logic        e_mv;
        int          e_id;
        logic [11:0] e_vlan;
        int          e_cnt;
        int          e_rdy;
        int          e_ovf;
    } vec_t;

    function automatic logic [SW-1:0] segs_of(input int id);
        logic [31:0] w;
        w = 32'hA500_0000 | 32'(id);
        return {(SW/32){w}};
    endfunction

    function automatic logic [TW-1:0] tuser_of(input int id);
        logic [31:0] w;
        w = 32'h7E00_0000 | 32'(id);
        return {(TW/32){w}};
    endfunction

    function automatic logic [11:0] vlan_of(input int id);
        return 12'(12'h400 + id);
    endfunction

    function automatic vec_t mk(input logic r, input logic sv, input int sid, input logic vv,
                                input logic [11:0] vl, input logic mr, input logic e_mv,
                                input int e_id, input logic [11:0] e_vlan, input int e_cnt,
                                input int e_rdy, input int e_ovf);
        vec_t v;
        v.rst = r; v.sv = sv; v.sid = sid; v.vv = vv; v.vlan = vl; v.mr = mr;
        v.e_mv = e_mv; v.e_id = e_id; v.e_vlan = e_vlan;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_wide(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got ..%08h expected ..%08h", name, act[31:0], exp[31:0]);
    endtask

    task automatic chk_head(input string name, input int id, input logic [11:0] vl);
        chk({name, " m_valid"}, 64'(m_valid), 64'd1);
        chk({name, " m_vlan"}, 64'(m_vlan), 64'(vl));
        chk_wide({name, " m_segs"}, m_segs_tdata, segs_of(id));
        chk({name, " m_tuser"}, 64'(m_tuser_1st[63:0]), 64'(tuser_of(id)));
    endtask

    // Drives one cycle's inputs after the falling edge; outputs are sampled 1 ns later.
    task automatic step(input logic r, input logic sv, input int sid, input logic vv,
                        input logic [11:0] vl, input logic mr);
        @(negedge clk);
        rst          = r;
        s_segs_valid = sv;
        s_segs_tdata = sv ? segs_of(sid) : '0;
        s_tuser_1st  = sv ? tuser_of(sid) : '0;
        s_vlan_valid = vv;
        s_vlan       = vl;
        m_ready      = mr;
        #1;
    endtask

    task automatic idle(input logic mr);
        step(1'b0, 1'b0, 0, 1'b0, 12'h0, mr);
    endtask

    vec_t vq[$];

    initial begin
        rst = 1'b1; s_segs_valid = 1'b0; s_segs_tdata = '0; s_tuser_1st = '0;
        s_vlan_valid = 1'b0; s_vlan = '0; m_ready = 1'b0;

        // reset, single packet, vlan lead, head hold under backpressure
        vq.push_back(mk(1,0,0,0,12'h0,0,   0,0,12'h0,-1,0,-1));
        vq.push_back(mk(1,0,0,0,12'h0,0,   0,0,12'h0, 0,0, 0));
        vq.push_back(mk(0,0,0,0,12'h0,0,   0,0,12'h0, 0,1, 0));
        vq.push_back(mk(0,0,0,1,12'h123,1, 0,0,12'h0, 0,1, 0));
        vq.push_back(mk(0,0,0,0,12'h0,1,   0,0,12'h0, 0,1, 0));
        vq.push_back(mk(0,1,1,0,12'h0,1,   0,0,12'h0, 0,1, 0));
        vq.push_back(mk(0,0,0,0,12'h0,1,   1,1,12'h123,1,1,0));
        vq.push_back(mk(0,0,0,0,12'h0,1,   0,0,12'h0, 0,1, 0));
        vq.push_back(mk(0,0,0,1,12'h201,1, 0,0,12'h0, 0,1, 0));
        vq.push_back(mk(0,0,0,1,12'h202,1, 0,0,12'h0, 0,1, 0));
        vq.push_back(mk(0,0,0,1,12'h203,1, 0,0,12'h0, 0,1, 0));
        for (int i = 0; i < 4; i++) vq.push_back(mk(0,0,0,0,12'h0,1, 0,0,12'h0,0,1,0));
        vq.push_back(mk(0,1,2,0,12'h0,1,   0,0,12'h0, 0,1, 0));
        vq.push_back(mk(0,1,3,0,12'h0,1,   1,2,12'h201,1,1,0));
        vq.push_back(mk(0,1,4,0,12'h0,1,   1,3,12'h202,1,1,0));
        vq.push_back(mk(0,0,0,0,12'h0,1,   1,4,12'h203,1,1,0));
        vq.push_back(mk(0,0,0,0,12'h0,1,   0,0,12'h0, 0,1, 0));
        vq.push_back(mk(0,0,0,1,12'h301,0, 0,0,12'h0, 0,1, 0));
        vq.push_back(mk(0,1,5,0,12'h0,0,   0,0,12'h0, 0,1, 0));
        vq.push_back(mk(0,0,0,0,12'h0,0,   1,5,12'h301,1,1,0));
        vq.push_back(mk(0,0,0,0,12'h0,0,   1,5,12'h301,1,1,0));
        vq.push_back(mk(0,0,0,0,12'h0,1,   1,5,12'h301,1,1,0));
        vq.push_back(mk(0,0,0,0,12'h0,1,   0,0,12'h0, 0,1, 0));

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].sv, vq[i].sid, vq[i].vv, vq[i].vlan, vq[i].mr);
            if (vq[i].e_mv) begin
                chk_head($sformatf("row%0d", i), vq[i].e_id, vq[i].e_vlan);
            end else begin
                chk($sformatf("row%0d m_valid", i), 64'(m_valid), 64'd0);
            end
            if (vq[i].rst) begin
                chk($sformatf("row%0d rst m_vlan", i), 64'(m_vlan), 64'd0);
                chk_wide($sformatf("row%0d rst m_segs", i), m_segs_tdata, '0);
            end
            if (vq[i].e_cnt >= 0) chk($sformatf("row%0d seg_count", i), 64'(seg_count), 64'(vq[i].e_cnt));
            if (vq[i].e_rdy >= 0) chk($sformatf("row%0d ready", i), 64'(segs_fifo_ready), 64'(vq[i].e_rdy));
            if (vq[i].e_ovf >= 0) chk($sformatf("row%0d overflow", i), 64'(overflow_err), 64'(vq[i].e_ovf));
        end

        // Fill with ready honoured one cycle late: 8 writes land, ready drops at count 7.
        for (int i = 10; i < 18; i++) step(1'b0, 1'b0, 0, 1'b1, vlan_of(i), 1'b0);
        begin
            logic prev_rdy;
            int   nw;
            prev_rdy = 1'b0;
            nw = 0;
            for (int c = 0; c < 10; c++) begin
                step(1'b0, prev_rdy, 10 + nw, 1'b0, 12'h0, 1'b0);
                chk($sformatf("fill c%0d seg_count", c), 64'(seg_count), 64'(nw));
                chk($sformatf("fill c%0d ready", c), 64'(segs_fifo_ready), 64'(nw < 7));
                if (prev_rdy && nw < 8) nw++;
                prev_rdy = segs_fifo_ready;
            end
        end
        idle(1'b0);
        chk("fill final seg_count", 64'(seg_count), 64'd8);
        chk("fill final overflow", 64'(overflow_err), 64'd0);
        chk("fill final ready", 64'(segs_fifo_ready), 64'd0);
        chk_head("fill head", 10, vlan_of(10));

        // Write at full without a pop is dropped; write at full with a pop is accepted.
        step(1'b0, 1'b1, 99, 1'b1, vlan_of(18), 1'b0);
        chk("ovf cycle seg_count", 64'(seg_count), 64'd8);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, i == 0, 18, 1'b0, 12'h0, 1'b1);
            chk_head($sformatf("drain%0d", i), 10 + i, vlan_of(10 + i));
            chk($sformatf("drain%0d seg_count", i), 64'(seg_count), 64'((i <= 1) ? 8 : 9 - i));
            chk($sformatf("drain%0d overflow", i), 64'(overflow_err), 64'd1);
        end
        idle(1'b1);
        chk("drained m_valid", 64'(m_valid), 64'd0);
        chk("drained seg_count", 64'(seg_count), 64'd0);
        chk("overflow sticky", 64'(overflow_err), 64'd1);

        // Reset with four stored entries; the next packet must be the first out.
        for (int i = 30; i < 34; i++) step(1'b0, 1'b0, 0, 1'b1, vlan_of(i), 1'b0);
        for (int i = 30; i < 34; i++) step(1'b0, 1'b1, i, 1'b0, 12'h0, 1'b0);
        idle(1'b0);
        chk("pre-rst seg_count", 64'(seg_count), 64'd4);
        chk_head("pre-rst", 30, vlan_of(30));
        step(1'b1, 1'b0, 0, 1'b0, 12'h0, 1'b0);
        chk("in-rst m_valid", 64'(m_valid), 64'd0);
        chk("in-rst ready", 64'(segs_fifo_ready), 64'd0);
        chk("in-rst m_vlan", 64'(m_vlan), 64'd0);
        idle(1'b0);
        chk("post-rst m_valid", 64'(m_valid), 64'd0);
        chk("post-rst seg_count", 64'(seg_count), 64'd0);
        chk("post-rst ready", 64'(segs_fifo_ready), 64'd1);
        chk("post-rst overflow", 64'(overflow_err), 64'd0);
        step(1'b0, 1'b0, 0, 1'b1, 12'h7AA, 1'b0);
        step(1'b0, 1'b1, 40, 1'b0, 12'h0, 1'b1);
        chk("post-rst empty", 64'(m_valid), 64'd0);
        idle(1'b1);
        chk_head("post-rst first", 40, 12'h7AA);
        idle(1'b1);
        chk("post-rst done", 64'(m_valid), 64'd0);

        // Streaming write+pop every cycle; 20 entries wrap both FIFOs twice.
        for (int k = 0; k < 23; k++) begin
            step(1'b0, (k >= 1 && k <= 20), 50 + k - 1, (k < 20), vlan_of(50 + k), 1'b1);
            if (k >= 2 && k <= 21) begin
                chk_head($sformatf("wrap k%0d", k), 50 + k - 2, vlan_of(50 + k - 2));
                chk($sformatf("wrap k%0d seg_count", k), 64'(seg_count), 64'd1);
            end else begin
                chk($sformatf("wrap k%0d m_valid", k), 64'(m_valid), 64'd0);
                chk($sformatf("wrap k%0d seg_count", k), 64'(seg_count), 64'd0);
            end
        end
        chk("wrap overflow", 64'(overflow_err), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/parser_segs_fifo.md
PARSER_SEGS_FIFO -- requirements
Module: parser_segs_fifo

Interface
REQ-001 Parameters SHALL be: C_AXIS_DATA_WIDTH, default 256, segment width; C_AXIS_TUSER_WIDTH, default 128, tuser width; C_NUM_SEGS, default 4, segments per entry; C_DEPTH_LOG2, default 3, log2 of segment-FIFO depth (DEPTH = 8).
REQ-002 axis_clk  in  1  sole clock; all logic on rising edge.
REQ-003 axis_rst  in  1  synchronous, active-high reset.
REQ-004 s_segs_tdata  in  C_NUM_SEGS*C_AXIS_DATA_WIDTH  packet header segments.
REQ-005 s_tuser_1st  in  C_AXIS_TUSER_WIDTH  first-beat tuser.
REQ-006 s_segs_valid  in  1  one-cycle write strobe for segs+tuser.
REQ-007 s_vlan  in  12  VLAN ID of packet.
REQ-008 s_vlan_valid  in  1  one-cycle write strobe for vlan; precedes its s_segs_valid by >=1 cycle.
REQ-009 segs_fifo_ready  out  1  upstream may assert s_segs_valid next cycle.
REQ-010 m_segs_tdata, m_tuser_1st, m_vlan  out  widths as inputs  head entry.
REQ-011 m_valid  out  1  head entry present in both FIFOs.
REQ-012 m_ready  in  1  downstream accepts head when m_valid && m_ready.
REQ-013 seg_count  out  C_DEPTH_LOG2+1  current segment-FIFO occupancy.
REQ-014 overflow_err  out  1  sticky, write attempted while full.

Function
REQ-015 Block SHALL hold a segment FIFO (DEPTH entries of segs+tuser) and a VLAN FIFO (DEPTH+1 entries of 12 bits), both circular with wrap-around pointers.
REQ-016 s_segs_valid SHALL write segs+tuser in the same cycle; s_vlan_valid SHALL write vlan in the same cycle; independent of each other.
REQ-017 segs_fifo_ready SHALL equal (seg_count < DEPTH-1), combinational from registered count, so a write issued one cycle after ready was sampled never overflows.
REQ-018 m_valid SHALL equal (segment FIFO non-empty) AND (VLAN FIFO non-empty); a read pops exactly one entry from each FIFO.
REQ-019 Outputs SHALL be first-word-fall-through: m_* show head entry whenever m_valid=1; data stable while m_valid && !m_ready.
REQ-020 Latency SHALL be one cycle: entry written at cycle t (with vlan already present) gives m_valid=1 at t+1.
REQ-021 Simultaneous write and read SHALL leave count unchanged, including when full (read frees slot first) and when empty (no read possible; count becomes 1).
REQ-022 Write to full segment FIFO (or full VLAN FIFO) SHALL be dropped, pointer/count unchanged, overflow_err set until reset.
REQ-023 Read with m_valid=0 SHALL have no effect.
REQ-024 Pointer wrap SHALL occur from last index to 0 with no lost or duplicated entry.
REQ-025 seg_count SHALL range 0..DEPTH and never exceed DEPTH.

Reset
REQ-026 While axis_rst=1: pointers, counts, m_valid=0, overflow_err=0, segs_fifo_ready=0; m_* data SHALL be 0.
REQ-027 First cycle after reset deassertion segs_fifo_ready SHALL be 1.
REQ-028 Reset mid-operation SHALL discard all stored entries; no stale entry appears afterwards.
REQ-029 Storage arrays need not be reset.

Verification
REQ-030 Single packet: vlan=0x123 at t0, segs=pattern A at t2, m_ready=1 -> m_valid=1 at t3 only, m_vlan=0x123, m_segs_tdata=A, seg_count returns 0 at t4.
REQ-031 Fill: m_ready=0, honour ready with one-cycle lag, push 8 packets -> segs_fifo_ready=0 when seg_count=7, 8th write accepted, seg_count=8, overflow_err=0.
REQ-032 Overflow: force s_segs_valid at seg_count=8 -> entry dropped, overflow_err=1 sticky, drained order unchanged.
REQ-033 Wrap/throughput: 20 packets with simultaneous write/read each cycle -> outputs in order, IDs 0..19, count constant, pointers wrap twice.
REQ-034 VLAN lead: 3 vlans then segs after 5 cycles -> m_valid=0 until segs written, then pairs match in order.
REQ-035 Reset with 4 entries stored -> m_valid=0 and seg_count=0 next cycle; new packet after reset is first out.
